// File: rtl/clk_switch_monitor_pkg.sv
// Shared types and default timing constants for the switched-clock monitor.
package clk_switch_monitor_pkg;

  typedef enum logic [1:0] {ACQ, LOCK, SWITCH} state_e;
  typedef enum logic [1:0] {M0, M1, SHORT, OTHER} run_cls_e;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_HALF0   = 8;
  localparam int DEF_HALF1   = 4;
  localparam int DEF_TOL     = 1;
  localparam int DEF_TIMEOUT = 64;

  function automatic logic in_tol(input int len, input int half, input int tol);
    return ((len + tol) >= half) && (len <= (half + tol));
  endfunction

endpackage

// File: rtl/clk_switch_monitor_run_meter.sv
// Synchronises mon_clk, detects its edges and measures each high/low run in clk cycles.
module run_meter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk_i,
  output logic             run_done_o,
  output logic             sat_o,
  output logic [CNT_W-1:0] last_run_o
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic             s1_q, s2_q, prev_q;
  logic             edge_det;
  logic [CNT_W-1:0] count_q;

  assign edge_det = s2_q ^ prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      count_q    <= '0;
      last_run_o <= '0;
      run_done_o <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      s1_q       <= mon_clk_i;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      run_done_o <= edge_det;
      sat_o      <= 1'b0;
      if (edge_det) begin
        // The closing cycle belongs to the run, hence +1 (clamped at MAX).
        last_run_o <= (count_q == MAX) ? MAX : count_q + CNT_W'(1);
        count_q    <= '0;
      end else if (count_q != MAX) begin
        count_q <= count_q + CNT_W'(1);
        sat_o   <= (count_q == MAX - CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/clk_switch_monitor.sv
// Receive-side checker for the clock switch: classifies mon_clk runs and tracks
// lock/switch progress against the synchronised select.
module clk_switch_monitor
  import clk_switch_monitor_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int HALF0   = DEF_HALF0,
  parameter int HALF1   = DEF_HALF1,
  parameter int TOL     = DEF_TOL,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             select,
  output logic             locked,
  output logic             src_id,
  output logic             switch_done,
  output logic             switch_tmo,
  output logic             glitch,
  output logic             stuck,
  output logic [CNT_W-1:0] last_run
);

  localparam int MINH  = (HALF0 < HALF1) ? HALF0 : HALF1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic       run_done, sat;
  int         run_len;
  run_cls_e   cls;
  logic       cls_match, cls_src, run_for_sel;
  logic       sel_s1_q, sel_sync_q, sel_prev_q, sel_chg;

  state_e             state_q;
  logic               locked_q, src_q, done_q, tmo_q, glitch_q, stuck_q;
  logic               mcnt_q, msrc_q;
  logic [TMR_W-1:0]   timer_q;

  run_meter #(.CNT_W(CNT_W)) u_meter (
    .clk        (clk),
    .rst        (rst),
    .mon_clk_i  (mon_clk),
    .run_done_o (run_done),
    .sat_o      (sat),
    .last_run_o (last_run)
  );

  assign run_len = int'(last_run);
  assign sel_chg = sel_sync_q ^ sel_prev_q;

  always_comb begin
    cls = OTHER;
    if (in_tol(run_len, HALF1, TOL))      cls = M1;
    else if (in_tol(run_len, HALF0, TOL)) cls = M0;
    else if (run_len < MINH - TOL)        cls = SHORT;
    cls_match   = (cls == M0) || (cls == M1);
    cls_src     = (cls == M1);
    run_for_sel = run_done && cls_match && (cls_src == sel_sync_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_s1_q   <= 1'b0;
      sel_sync_q <= 1'b0;
      sel_prev_q <= 1'b0;
      state_q    <= ACQ;
      locked_q   <= 1'b0;
      src_q      <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      glitch_q   <= 1'b0;
      stuck_q    <= 1'b0;
      mcnt_q     <= 1'b0;
      msrc_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      sel_s1_q   <= select;
      sel_sync_q <= sel_s1_q;
      sel_prev_q <= sel_sync_q;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      stuck_q    <= 1'b0;
      glitch_q   <= run_done && (cls == SHORT);
      case (state_q)
        ACQ: if (run_done) begin
          if (cls_match && mcnt_q && (msrc_q == cls_src)) begin
            state_q  <= LOCK;
            src_q    <= cls_src;
            locked_q <= 1'b1;
            mcnt_q   <= 1'b0;
          end else begin
            mcnt_q <= cls_match;
            msrc_q <= cls_src;
          end
        end
        LOCK: begin
          // A run closing alongside the select change is judged as the first SWITCH run.
          if (sel_sync_q != src_q) begin
            state_q  <= SWITCH;
            locked_q <= 1'b0;
            timer_q  <= '0;
            mcnt_q   <= run_for_sel;
          end else if (sat) begin
            stuck_q  <= 1'b1;
            state_q  <= ACQ;
            locked_q <= 1'b0;
            mcnt_q   <= 1'b0;
          end else if (run_done && !(cls_match && (cls_src == src_q))) begin
            state_q  <= ACQ;
            locked_q <= 1'b0;
            mcnt_q   <= 1'b0;
          end
        end
        SWITCH: begin
          if (sel_chg) begin
            timer_q <= '0;
            mcnt_q  <= run_for_sel;
          end else if (timer_q == TMR_W'(TIMEOUT)) begin
            tmo_q   <= 1'b1;
            state_q <= ACQ;
            mcnt_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (run_for_sel) begin
              if (mcnt_q) begin
                state_q  <= LOCK;
                src_q    <= sel_sync_q;
                locked_q <= 1'b1;
                done_q   <= 1'b1;
                mcnt_q   <= 1'b0;
              end else begin
                mcnt_q <= 1'b1;
              end
            end else if (run_done) begin
              mcnt_q <= 1'b0;
            end
          end
        end
        default: state_q <= ACQ;
      endcase
    end
  end

  assign locked      = locked_q;
  assign src_id      = src_q;
  assign switch_done = done_q;
  assign switch_tmo  = tmo_q;
  assign glitch      = glitch_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_clk_switch_monitor.sv
// Directed bench for clk_switch_monitor: mon_clk is generated at clk negedges
// with a programmable half-period so run lengths are exact.
module tb_clk_switch_monitor;
  import clk_switch_monitor_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, mon_clk = 1'b0, select = 1'b1;
  logic       locked, src_id, switch_done, switch_tmo, glitch, stuck;
  logic [7:0] last_run;

  int   vec = 0, errs = 0;
  int   gen_half = 0, gen_cnt = 0;
  logic lvl = 1'b0;
  int   n_done = 0, n_tmo = 0, n_glitch = 0, n_stuck = 0, n_fall = 0;
  logic locked_prev = 1'b0;

  clk_switch_monitor #(
    .CNT_W(DEF_CNT_W), .HALF0(DEF_HALF0), .HALF1(DEF_HALF1),
    .TOL(DEF_TOL), .TIMEOUT(DEF_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .mon_clk(mon_clk), .select(select),
    .locked(locked), .src_id(src_id), .switch_done(switch_done),
    .switch_tmo(switch_tmo), .glitch(glitch), .stuck(stuck), .last_run(last_run)
  );

  always #5 clk = ~clk;

  // Pulse tallies; tests compare deltas taken across each scenario.
  always @(negedge clk) begin
    if (!rst) begin
      if (switch_done) n_done <= n_done + 1;
      if (switch_tmo)  n_tmo <= n_tmo + 1;
      if (glitch)      n_glitch <= n_glitch + 1;
      if (stuck)       n_stuck <= n_stuck + 1;
      if (locked_prev && !locked) n_fall <= n_fall + 1;
    end
    locked_prev <= locked;
  end

  task automatic step();
    @(negedge clk);
    if (gen_half != 0) begin
      gen_cnt++;
      if (gen_cnt >= gen_half) begin
        gen_cnt = 0;
        lvl = ~lvl;
      end
    end
    mon_clk = lvl;
  endtask

  task automatic set_half(input int h);
    gen_half = h;
    gen_cnt  = 0;
  endtask

  task automatic force_lvl(input logic l);
    lvl     = l;
    gen_cnt = 0;
    mon_clk = l;
  endtask

  // Advance until mon_clk has just fallen; bounded.
  task automatic wait_fall(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = (lvl == 1'b0) && (gen_cnt == 0);
    end
    if (!ok) begin
      vec++; errs++;
      $display("FAIL %s: run boundary not reached within 40 cycles", tag);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    vec++; if (locked !== 1'b0) begin errs++; $display("FAIL reset_locked: got %b want 0", locked); end
    vec++; if (src_id !== 1'b0) begin errs++; $display("FAIL reset_src: got %b want 0", src_id); end
    vec++; if ({switch_done, switch_tmo, glitch, stuck} !== 4'b0) begin errs++;
      $display("FAIL reset_pulses: got %b want 0000", {switch_done, switch_tmo, glitch, stuck}); end
    vec++; if (last_run !== 8'd0) begin errs++; $display("FAIL reset_last_run: got %0d want 0", last_run); end
    rst = 1'b0;
    repeat (10) step();
    set_half(4);
    repeat (30) step();
    vec++; if (locked !== 1'b1) begin errs++; $display("FAIL acq_locked: got %b want 1", locked); end
    vec++; if (src_id !== 1'b1) begin errs++; $display("FAIL acq_src: got %b want 1", src_id); end
    vec++; if (n_glitch !== 0) begin errs++; $display("FAIL acq_glitch: got %0d pulses want 0", n_glitch); end
    vec++; if (n_stuck !== 0) begin errs++; $display("FAIL acq_stuck: got %0d pulses want 0", n_stuck); end
  endtask

  task automatic test_glitch();
    int g0, f0;
    g0 = n_glitch; f0 = n_fall;
    wait_fall("glitch");
    set_half(0);
    repeat (4) step();
    force_lvl(1'b1);
    step();
    force_lvl(1'b0);
    set_half(4);
    repeat (6) step();
    vec++; if (locked !== 1'b0) begin errs++; $display("FAIL glitch_unlock: got %b want 0", locked); end
    repeat (24) step();
    vec++; if (n_glitch - g0 !== 1) begin errs++; $display("FAIL glitch_count: got %0d want 1", n_glitch - g0); end
    vec++; if (n_fall - f0 !== 1) begin errs++; $display("FAIL glitch_lockdrop: got %0d want 1", n_fall - f0); end
    vec++; if (locked !== 1'b1) begin errs++; $display("FAIL glitch_relock: got %b want 1", locked); end
    vec++; if (src_id !== 1'b1) begin errs++; $display("FAIL glitch_src: got %b want 1", src_id); end
  endtask

  task automatic test_timeout();
    int t0, d0, k;
    t0 = n_tmo; d0 = n_done; k = -1;
    select = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (switch_tmo === 1'b1) begin k = i; break; end
    end
    // Two select sync stages, then timer 0..TIMEOUT, then the registered pulse.
    vec++; if (k < DEF_TIMEOUT + 2 || k > DEF_TIMEOUT + 6) begin errs++;
      $display("FAIL tmo_latency: got %0d want %0d..%0d", k, DEF_TIMEOUT + 2, DEF_TIMEOUT + 6); end
    vec++; if (locked !== 1'b0) begin errs++; $display("FAIL tmo_locked: got %b want 0", locked); end
    select = 1'b1;
    repeat (30) step();
    vec++; if (n_tmo - t0 !== 1) begin errs++; $display("FAIL tmo_count: got %0d want 1", n_tmo - t0); end
    vec++; if (n_done - d0 !== 0) begin errs++; $display("FAIL tmo_no_done: got %0d want 0", n_done - d0); end
    vec++; if (locked !== 1'b1) begin errs++; $display("FAIL tmo_relock: got %b want 1", locked); end
    vec++; if (src_id !== 1'b1) begin errs++; $display("FAIL tmo_src: got %b want 1", src_id); end
  endtask

  task automatic test_switch();
    int t0, d0;
    t0 = n_tmo; d0 = n_done;
    wait_fall("switch");
    select = 1'b0;
    set_half(0);
    repeat (12) step();
    force_lvl(1'b1);
    set_half(8);
    repeat (6) step();
    vec++; if (locked !== 1'b0) begin errs++; $display("FAIL sw_in_switch: got %b want 0", locked); end
    repeat (40) step();
    vec++; if (n_done - d0 !== 1) begin errs++; $display("FAIL sw_done: got %0d want 1", n_done - d0); end
    vec++; if (n_tmo - t0 !== 0) begin errs++; $display("FAIL sw_no_tmo: got %0d want 0", n_tmo - t0); end
    vec++; if (locked !== 1'b1) begin errs++; $display("FAIL sw_locked: got %b want 1", locked); end
    vec++; if (src_id !== 1'b0) begin errs++; $display("FAIL sw_src: got %b want 0", src_id); end
  endtask

  task automatic test_stuck();
    int s0;
    s0 = n_stuck;
    vec++; if (locked !== 1'b1) begin errs++; $display("FAIL stuck_pre_lock: got %b want 1", locked); end
    wait_fall("stuck");
    force_lvl(1'b1);
    set_half(0);
    repeat (300) step();
    vec++; if (n_stuck - s0 !== 1) begin errs++; $display("FAIL stuck_count: got %0d want 1", n_stuck - s0); end
    vec++; if (locked !== 1'b0) begin errs++; $display("FAIL stuck_unlock: got %b want 0", locked); end
    force_lvl(1'b0);
    repeat (5) step();
    vec++; if (last_run !== 8'd255) begin errs++; $display("FAIL stuck_last_run: got %0d want 255", last_run); end
    set_half(8);
    repeat (50) step();
    vec++; if (locked !== 1'b1 || src_id !== 1'b0) begin errs++;
      $display("FAIL stuck_relock: got locked=%b src=%b want 1/0", locked, src_id); end
  endtask

  task automatic test_rst_mid_switch();
    select = 1'b1;
    repeat (10) step();
    vec++; if (dut.state_q !== SWITCH || locked !== 1'b0) begin errs++;
      $display("FAIL rst_pre_switch: got state=%0d locked=%b want %0d/0", int'(dut.state_q), locked, int'(SWITCH)); end
    rst = 1'b1;
    step();
    vec++; if ({locked, src_id, switch_done, switch_tmo, glitch, stuck} !== 6'b0) begin errs++;
      $display("FAIL rst_outputs: got %b want 000000", {locked, src_id, switch_done, switch_tmo, glitch, stuck}); end
    vec++; if (last_run !== 8'd0) begin errs++; $display("FAIL rst_last_run: got %0d want 0", last_run); end
    vec++; if (dut.state_q !== ACQ) begin errs++; $display("FAIL rst_state: got %0d want %0d", int'(dut.state_q), int'(ACQ)); end
    vec++; if (dut.u_meter.count_q !== 8'd0 || dut.timer_q !== '0) begin errs++;
      $display("FAIL rst_counters: got count=%0d timer=%0d want 0/0", dut.u_meter.count_q, dut.timer_q); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_timeout();
    test_switch();
    test_stuck();
    test_rst_mid_switch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
